// File: rtl/divider.sv
// Unsigned 32-bit restoring shift-subtract divider, one quotient bit per clock.
// Result packed as {remainder, quotient}; companion to the shift-add multiplier.
module divider (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [5:0]  Signal,
  output logic [63:0] dataOut,
  output logic        busy,
  output logic        done,
  output logic        divZero
);

  localparam logic [5:0] DIVU = 6'b011011;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q;
  logic [5:0]  count_q;
  logic [31:0] divisor_q;
  logic [63:0] rq_q;

  logic [64:0] shifted;
  logic        ge;
  logic [31:0] diff;
  logic [63:0] rq_next;

  // Compare on 33 bits: shifted[64] is the carry out of the shift, which can be set
  // once the partial remainder exceeds 2^31. When ge holds, the true difference fits
  // in 32 bits, so a 32-bit subtract is exact.
  always_comb begin
    shifted = {rq_q, 1'b0};
    ge      = shifted[64] | (shifted[63:32] >= divisor_q);
    diff    = shifted[63:32] - divisor_q;
    rq_next = shifted[63:0];
    if (ge) begin
      rq_next = {diff, shifted[31:1], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      divisor_q <= '0;
      rq_q      <= '0;
      dataOut   <= '0;
      divZero   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Signal == DIVU) begin
            rq_q      <= {32'b0, dataA};
            divisor_q <= dataB;
            count_q   <= '0;
            state_q   <= StRun;
          end
        end
        StRun: begin
          rq_q    <= rq_next;
          count_q <= count_q + 6'd1;
          if (count_q == 6'd31) begin
            dataOut <= rq_next;
            divZero <= (divisor_q == 32'd0);
            state_q <= StDone;
          end
        end
        StDone: begin
          // A held DIVU must not restart; the op code has to drop first.
          if (Signal != DIVU) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_divider.sv
// Directed, table-driven bench for the sequential divider plus hand-written
// sequences for operand stability, held DIVU and reset mid-run.
module tb_divider;

  localparam logic [5:0] DIVU = 6'b011011;

  logic        clk;
  logic        reset;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic [63:0] dataOut;
  logic        busy;
  logic        done;
  logic        divZero;

  int checks = 0;
  int errors = 0;

  divider dut (
    .clk    (clk),
    .reset  (reset),
    .dataA  (dataA),
    .dataB  (dataB),
    .Signal (Signal),
    .dataOut(dataOut),
    .busy   (busy),
    .done   (done),
    .divZero(divZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp_out;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Call with the DUT just past the start edge; returns cycles until done and
  // the number of sampled cycles with busy high.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dataA  = a;
    dataB  = b;
    Signal = DIVU;
    @(posedge clk);
    #1;
  endtask

  task automatic release_op();
    @(negedge clk);
    Signal = 6'b111111;
    @(posedge clk);
    #1;
    check("release_done_low", {63'b0, done}, 64'd0);
  endtask

  int lat;
  int bcnt;
  logic held_ok;

  initial begin
    vecs[0] = '{32'd100,        32'd7,          64'h00000002_0000000E, 1'b0};
    vecs[1] = '{32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 1'b0};
    vecs[2] = '{32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 1'b0};
    vecs[3] = '{32'd3,          32'd10,         64'h00000003_00000000, 1'b0};
    vecs[4] = '{32'd5,          32'd0,          64'h00000005_FFFFFFFF, 1'b1};
    vecs[5] = '{32'd9,          32'd3,          64'h00000000_00000003, 1'b0};
    vecs[6] = '{32'hFFFFFFFF,   32'h80000000,   64'h7FFFFFFF_00000001, 1'b0};
    vecs[7] = '{32'hFFFFFFFE,   32'hFFFFFFFF,   64'hFFFFFFFE_00000000, 1'b0};

    reset  = 1'b0;
    dataA  = '0;
    dataB  = '0;
    Signal = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dataOut", dataOut, 64'd0);
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_done", {63'b0, done}, 64'd0);
    check("reset_divZero", {63'b0, divZero}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      start(vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy_start", i), {63'b0, busy}, 64'd1);
      wait_done(lat, bcnt);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'd32);
      check($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'd32);
      check($sformatf("v%0d_dataOut", i), dataOut, vecs[i].exp_out);
      check($sformatf("v%0d_divZero", i), {63'b0, divZero}, {63'b0, vecs[i].exp_dz});
      check($sformatf("v%0d_busy_end", i), {63'b0, busy}, 64'd0);
      release_op();
    end

    // Operands change at E5; latched values must be used.
    start(32'd1000, 32'd10);
    repeat (5) @(posedge clk);
    #1;
    dataB = 32'd3;
    dataA = 32'd0;
    wait_done(lat, bcnt);
    check("stable_latency", 64'(lat), 64'd27);
    check("stable_dataOut", dataOut, 64'h00000000_00000064);

    // DIVU held 50 cycles past completion: no restart.
    held_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b1 || busy !== 1'b0 || dataOut !== 64'h64) held_ok = 1'b0;
    end
    check("held_no_restart", {63'b0, held_ok}, 64'd1);
    @(negedge clk);
    Signal = '0;
    @(posedge clk);
    #1;
    check("held_drop_done", {63'b0, done}, 64'd0);
    check("held_drop_busy", {63'b0, busy}, 64'd0);
    start(32'd77, 32'd7);
    check("restart_busy", {63'b0, busy}, 64'd1);
    check("restart_hold_old", dataOut, 64'h00000000_00000064);
    wait_done(lat, bcnt);
    check("restart_latency", 64'(lat), 64'd32);
    check("restart_dataOut", dataOut, 64'h00000000_0000000B);
    release_op();

    // Reset asserted at E10 of a 100 / 7 run.
    start(32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    Signal = '0;
    @(posedge clk);
    #1;
    check("midreset_dataOut", dataOut, 64'd0);
    check("midreset_busy", {63'b0, busy}, 64'd0);
    check("midreset_done", {63'b0, done}, 64'd0);
    check("midreset_divZero", {63'b0, divZero}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    start(32'd50, 32'd6);
    wait_done(lat, bcnt);
    check("post_reset_latency", 64'(lat), 64'd32);
    check("post_reset_dataOut", dataOut, 64'h00000002_00000008);
    release_op();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
